// File: rtl/banked_sync_ram.sv
// -----------------------------------------------------------------------------
// banked_sync_ram
//   Banked single-port synchronous RAM with per-lane write enables and a
//   zero-fill scrubber. The top BANK_BITS address bits select the bank and the
//   remaining bits select the row. After reset, and whenever scrub_req is seen
//   in IDLE, the INIT state writes zero to one row of every bank per cycle.
//   Requests are only taken in IDLE.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (memory contents are not reset)
//   req_valid    request present
//   req_ready    request can be accepted (state == IDLE)
//   req_we       1 = write, 0 = read
//   req_addr     word address {bank, row}
//   req_wdata    write data
//   req_lane_en  per-lane write enable (ignored for reads)
//   scrub_req    request a zero-fill of the whole memory
//   rsp_valid    one-cycle pulse, read data valid
//   rsp_rdata    read data, holds its value while rsp_valid is 0
//   rsp_bank     bank that served the read, holds while rsp_valid is 0
//   init_done    high while in IDLE
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready depends only on FSM state, never on req_valid. A taken read shows
// rsp_valid for exactly the following cycle; a taken write never responds.
// -----------------------------------------------------------------------------
module banked_sync_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int BANK_BITS  = 2,
  parameter int LANES      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_lane_en,
  input  logic                  scrub_req,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [BANK_BITS-1:0]  rsp_bank,
  output logic                  init_done
);

  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int NUM_ROWS  = 1 << ROW_BITS;
  localparam int LANE_W    = DATA_WIDTH / LANES;

  if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("banked_sync_ram: DATA_WIDTH must be a multiple of LANES");
  end
  if (ADDR_WIDTH <= BANK_BITS) begin : g_bad_addr
    $error("banked_sync_ram: ADDR_WIDTH must exceed BANK_BITS");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e                state_q,     state_d;
  logic [ROW_BITS-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [BANK_BITS-1:0]  rsp_bank_q,  rsp_bank_d;

  logic [DATA_WIDTH-1:0] mem [0:NUM_BANKS-1][0:NUM_ROWS-1];

  logic [BANK_BITS-1:0] req_bank;
  logic [ROW_BITS-1:0]  req_row;
  logic                 accept;
  logic                 rd_fire;
  logic                 wr_fire;

  assign req_bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign req_row  = req_addr[ROW_BITS-1:0];
  assign accept   = req_valid && (state_q == ST_IDLE);
  assign rd_fire  = accept && !req_we;
  assign wr_fire  = accept && req_we;

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    rsp_valid_d = rd_fire;
    rsp_rdata_d = rsp_rdata_q;
    rsp_bank_d  = rsp_bank_q;

    case (state_q)
      ST_INIT: begin
        if (scrub_cnt_q == {ROW_BITS{1'b1}}) begin
          state_d     = ST_IDLE;
          scrub_cnt_d = '0;
        end else begin
          scrub_cnt_d = scrub_cnt_q + ROW_BITS'(1);
        end
      end
      ST_IDLE: begin
        // A request in the same cycle is still served; the scrub only starts
        // writing on the following cycle, so a read here sees pre-scrub data.
        if (scrub_req) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d     = ST_INIT;
        scrub_cnt_d = '0;
      end
    endcase

    if (rd_fire) begin
      rsp_rdata_d = mem[req_bank][req_row];
      rsp_bank_d  = req_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      scrub_cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_bank_q  <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  // Storage has no reset; only the scrubber clears it. Scrub and writes are
  // mutually exclusive because writes are only taken in IDLE.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        mem[b][scrub_cnt_q] <= '0;
      end
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (req_lane_en[l]) begin
          mem[req_bank][req_row][l*LANE_W +: LANE_W] <= req_wdata[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign init_done = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_bank  = rsp_bank_q;

endmodule
